tjmono2_rx_align: RTL and testbench

Automatic link-alignment controller for the TJ-Monopix2 RX datapath. Sweeps every combination of sampling edge (2) and input delay tap (32), measures link quality at each setting, then applies the centre of the longest error-free delay window. Sits in the BUS_CLK domain beside the RX core and drives its delay/edge configuration and receiver reset in place of software register writes.

---
 rtl/tjmono2_rx_align_pkg.sv | 25 ++
 rtl/tjmono2_rx_align_run.sv | 52 +++++
 rtl/tjmono2_rx_align.sv | 175 +++++++++++++++++
 tb/tb_tjmono2_rx_align.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/tjmono2_rx_align_pkg.sv
// Shared types and constants for the TJ-Monopix2 RX link-alignment controller.
package tjmono2_rx_align_pkg;

  localparam int NUM_DLY  = 32;
  localparam int NUM_EDGE = 2;
  localparam int NUM_SET  = 64;
  localparam int IDX_W    = 6;
  localparam int CNT_W    = 16;

  localparam logic [4:0] DEF_DLY  = 5'd2;
  localparam logic       DEF_EDGE = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETTLE,
    ST_MEASURE,
    ST_EVAL,
    ST_CHOOSE,
    ST_APPLY,
    ST_DONE,
    ST_FAIL
  } state_e;

endpackage

// File: rtl/tjmono2_rx_align_run.sv
// Longest-passing-run tracker; a run restarts at tap 0 so it never spans edges.
module tjmono2_rx_align_run
  import tjmono2_rx_align_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             step_i,
  input  logic             pass_i,
  input  logic [IDX_W-1:0] idx_i,
  output logic [IDX_W-1:0] best_start_o,
  output logic [5:0]       best_len_o
);

  logic [5:0]       cur_len_q;
  logic [5:0]       best_len_q;
  logic [IDX_W-1:0] best_start_q;
  logic [5:0]       base_len;
  logic [5:0]       new_len;

  always_comb begin
    base_len = (idx_i[4:0] == 5'd0) ? 6'd0 : cur_len_q;
    new_len  = base_len + 6'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cur_len_q    <= '0;
      best_len_q   <= '0;
      best_start_q <= '0;
    end else if (clear_i) begin
      cur_len_q    <= '0;
      best_len_q   <= '0;
      best_start_q <= '0;
    end else if (step_i) begin
      if (pass_i) begin
        cur_len_q <= new_len;
        // strictly greater: ties keep the earlier (lower index) run
        if (new_len > best_len_q) begin
          best_len_q   <= new_len;
          best_start_q <= idx_i - new_len + 6'd1;
        end
      end else begin
        cur_len_q <= '0;
      end
    end
  end

  assign best_start_o = best_start_q;
  assign best_len_o   = best_len_q;

endmodule

// File: rtl/tjmono2_rx_align.sv
// Edge/delay sweep controller: IDLE LOAD SETTLE MEASURE EVAL CHOOSE APPLY DONE FAIL.
// Define TJMONO2_RX_ALIGN_PASS_MAP_EN to implement the 64-bit PASS_MAP register.
module tjmono2_rx_align
  import tjmono2_rx_align_pkg::*;
#(
  parameter int SETTLE_CYCLES = 256,
  parameter int WINDOW_CYCLES = 4096,
  parameter int MIN_RUN       = 3
) (
  input  logic        BUS_CLK,
  input  logic        BUS_RST_N,
  input  logic        START,
  input  logic        ABORT,
  input  logic        RX_READY,
  input  logic        RX_DEC_ERR,
  output logic [4:0]  CONF_RX_DATA_DLY,
  output logic        CONF_SAMPLING_EDGE,
  output logic        CONF_LOAD,
  output logic        RX_RST,
  output logic        BUSY,
  output logic        DONE,
  output logic        FAIL,
  output logic [5:0]  BEST_LEN,
  output logic [63:0] PASS_MAP
);

  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WINDOW_LD = CNT_W'(WINDOW_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_SET - 1);

  state_e           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [CNT_W-1:0] cnt_q;
  logic             bad_q;
  logic [IDX_W-1:0] cfg_q;
  logic [IDX_W-1:0] last_q;
  logic             load_q, rx_rst_q, busy_q, done_q, fail_q;

  logic             abort_go, start_go, step;
  logic [IDX_W-1:0] best_start, sel;
  logic [5:0]       best_len;

  assign abort_go = ABORT && (state_q != ST_IDLE);
  assign start_go = START && !ABORT &&
                    (state_q == ST_IDLE || state_q == ST_DONE || state_q == ST_FAIL);
  assign step     = (state_q == ST_EVAL) && !abort_go;
  assign sel      = best_start + IDX_W'((best_len - 6'd1) >> 1);

  tjmono2_rx_align_run u_run (
    .clk_i        (BUS_CLK),
    .rst_ni       (BUS_RST_N),
    .clear_i      (start_go),
    .step_i       (step),
    .pass_i       (!bad_q),
    .idx_i        (idx_q),
    .best_start_o (best_start),
    .best_len_o   (best_len)
  );

  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      bad_q    <= 1'b0;
      cfg_q    <= {DEF_EDGE, DEF_DLY};
      last_q   <= {DEF_EDGE, DEF_DLY};
      load_q   <= 1'b0;
      rx_rst_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      fail_q   <= 1'b0;
    end else begin
      load_q   <= 1'b0;
      rx_rst_q <= 1'b0;
      if (abort_go) begin
        state_q <= ST_IDLE;
        cfg_q   <= last_q;
        load_q  <= 1'b1;
        busy_q  <= 1'b0;
        done_q  <= 1'b0;
        fail_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE, ST_DONE, ST_FAIL: begin
            if (start_go) begin
              state_q  <= ST_LOAD;
              idx_q    <= '0;
              cfg_q    <= '0;
              load_q   <= 1'b1;
              rx_rst_q <= 1'b1;
              busy_q   <= 1'b1;
              done_q   <= 1'b0;
              fail_q   <= 1'b0;
            end
          end
          ST_LOAD: begin
            state_q <= ST_SETTLE;
            cnt_q   <= SETTLE_LD;
          end
          ST_SETTLE: begin
            if (cnt_q == '0) begin
              state_q <= ST_MEASURE;
              cnt_q   <= WINDOW_LD;
              bad_q   <= 1'b0;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          ST_MEASURE: begin
            if (!RX_READY || RX_DEC_ERR) bad_q <= 1'b1;
            if (cnt_q == '0) state_q <= ST_EVAL;
            else             cnt_q   <= cnt_q - 1'b1;
          end
          ST_EVAL: begin
            if (idx_q == LAST_IDX) begin
              state_q <= ST_CHOOSE;
            end else begin
              state_q  <= ST_LOAD;
              idx_q    <= idx_q + 1'b1;
              cfg_q    <= idx_q + 1'b1;
              load_q   <= 1'b1;
              rx_rst_q <= 1'b1;
            end
          end
          ST_CHOOSE: begin
            if (best_len < 6'(MIN_RUN)) begin
              state_q <= ST_FAIL;
              cfg_q   <= last_q;
              load_q  <= 1'b1;
              busy_q  <= 1'b0;
              fail_q  <= 1'b1;
            end else begin
              state_q  <= ST_APPLY;
              cfg_q    <= sel;
              last_q   <= sel;
              load_q   <= 1'b1;
              rx_rst_q <= 1'b1;
            end
          end
          ST_APPLY: begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef TJMONO2_RX_ALIGN_PASS_MAP_EN
  logic [63:0] pass_map_q;

  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N)    pass_map_q        <= '0;
    else if (start_go) pass_map_q        <= '0;
    else if (step)     pass_map_q[idx_q] <= !bad_q;
  end

  assign PASS_MAP = pass_map_q;
`else
  assign PASS_MAP = '0;
`endif

  assign CONF_SAMPLING_EDGE = cfg_q[5];
  assign CONF_RX_DATA_DLY   = cfg_q[4:0];
  assign CONF_LOAD          = load_q;
  assign RX_RST             = rx_rst_q;
  assign BUSY               = busy_q;
  assign DONE               = done_q;
  assign FAIL               = fail_q;
  assign BEST_LEN           = best_len;

endmodule

// File: tb/tb_tjmono2_rx_align.sv
// Directed bench for tjmono2_rx_align with a pass-mask driven RX link model.
module tb_tjmono2_rx_align;

  localparam int S = 4;
  localparam int W = 8;
  localparam int P = S + W + 2;

  logic        clk = 1'b0;
  logic        rst_n, start, abort;
  logic        rx_ready, rx_dec_err;
  logic [4:0]  dly;
  logic        sedge, conf_load, rx_rst, busy, done, fail;
  logic [5:0]  best_len;
  logic [63:0] pass_map;

  logic [63:0] mask;
  logic        glitch_en;
  logic [7:0]  since_load;

  int checks = 0;
  int failures = 0;
  int loads, rsts, dur;
  bit timed_out, busy_gap;

  always #5 clk = ~clk;

  tjmono2_rx_align #(.SETTLE_CYCLES(S), .WINDOW_CYCLES(W), .MIN_RUN(3)) dut (
    .BUS_CLK            (clk),
    .BUS_RST_N          (rst_n),
    .START              (start),
    .ABORT              (abort),
    .RX_READY           (rx_ready),
    .RX_DEC_ERR         (rx_dec_err),
    .CONF_RX_DATA_DLY   (dly),
    .CONF_SAMPLING_EDGE (sedge),
    .CONF_LOAD          (conf_load),
    .RX_RST             (rx_rst),
    .BUSY               (busy),
    .DONE               (done),
    .FAIL               (fail),
    .BEST_LEN           (best_len),
    .PASS_MAP           (pass_map)
  );

  // Link model: good where mask is set; glitch mode raises a decoder error mid-window
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 since_load <= 8'd0;
    else if (conf_load)         since_load <= 8'd0;
    else if (since_load != 8'hff) since_load <= since_load + 8'd1;
  end
  assign rx_ready   = mask[{sedge, dly}];
  assign rx_dec_err = glitch_en && (since_load >= 8'd8);

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic run_sweep();
    int c0;
    c0 = -1; loads = 0; rsts = 0; dur = 0; timed_out = 1'b1; busy_gap = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (conf_load) begin loads++; if (c0 < 0) c0 = c; end
      if (rx_rst) rsts++;
      if (done || fail) begin dur = c - c0; timed_out = 1'b0; break; end
      if (!busy) busy_gap = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if ({sedge, dly} !== 6'd34) begin failures++; $display("FAIL reset_cfg got=%0d exp=34", {sedge, dly}); end
    checks++; if ({conf_load, rx_rst, busy, done, fail} !== 5'b0) begin failures++; $display("FAIL reset_flags got=%b exp=00000", {conf_load, rx_rst, busy, done, fail}); end
    checks++; if (best_len !== 6'd0 || pass_map !== 64'd0) begin failures++; $display("FAIL reset_len_map len=%0d map=%h exp=0/0", best_len, pass_map); end
    mask = '1; glitch_en = 1'b0;
    start = 1'b1; @(negedge clk); start = 1'b0;
    repeat (30) @(negedge clk);
    checks++; if ({sedge, dly} !== 6'd2) begin failures++; $display("FAIL midsweep_cfg got=%0d exp=2", {sedge, dly}); end
    rst_n = 1'b0; #1;
    checks++; if ({sedge, dly} !== 6'd34 || busy !== 1'b0 || conf_load !== 1'b0) begin failures++; $display("FAIL async_reset cfg=%0d busy=%b load=%b exp=34/0/0", {sedge, dly}, busy, conf_load); end
    @(negedge clk); rst_n = 1'b1; @(negedge clk);
    checks++; if (conf_load !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL post_reset load=%b busy=%b exp=0/0", conf_load, busy); end
  endtask

  task automatic test_fail();
    do_reset();
    mask = '1; glitch_en = 1'b1;
    run_sweep();
    checks++; if (timed_out) begin failures++; $display("FAIL fail_timeout got=timeout exp=FAIL asserted"); end
    checks++; if (fail !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL fail_flags fail=%b done=%b exp=1/0", fail, done); end
    checks++; if ({sedge, dly} !== 6'd34) begin failures++; $display("FAIL fail_restore got=%0d exp=34", {sedge, dly}); end
    checks++; if (conf_load !== 1'b1 || rx_rst !== 1'b0) begin failures++; $display("FAIL fail_entry_pulse load=%b rst=%b exp=1/0", conf_load, rx_rst); end
    checks++; if (loads !== 65 || rsts !== 64) begin failures++; $display("FAIL fail_pulses loads=%0d rsts=%0d exp=65/64", loads, rsts); end
    checks++; if (dur !== 64 * P + 1) begin failures++; $display("FAIL fail_duration got=%0d exp=%0d", dur, 64 * P + 1); end
    checks++; if (best_len !== 6'd0 || pass_map !== 64'd0) begin failures++; $display("FAIL fail_len_map len=%0d map=%h exp=0/0", best_len, pass_map); end
    @(negedge clk);
    checks++; if (conf_load !== 1'b0 || busy !== 1'b0 || fail !== 1'b1) begin failures++; $display("FAIL fail_after load=%b busy=%b fail=%b exp=0/0/1", conf_load, busy, fail); end
    glitch_en = 1'b0;
  endtask

  task automatic test_single_run();
    mask = 64'h0001_FC00_0000_0000;
    run_sweep();
    checks++; if (timed_out || done !== 1'b1 || fail !== 1'b0) begin failures++; $display("FAIL single_flags to=%b done=%b fail=%b exp=0/1/0", timed_out, done, fail); end
    checks++; if (best_len !== 6'd7) begin failures++; $display("FAIL single_len got=%0d exp=7", best_len); end
    checks++; if (sedge !== 1'b1 || dly !== 5'd13) begin failures++; $display("FAIL single_cfg edge=%b dly=%0d exp=1/13", sedge, dly); end
    checks++; if (loads !== 65 || rsts !== 65) begin failures++; $display("FAIL single_pulses loads=%0d rsts=%0d exp=65/65", loads, rsts); end
    checks++; if (dur !== 64 * P + 2) begin failures++; $display("FAIL single_duration got=%0d exp=%0d", dur, 64 * P + 2); end
    checks++; if (busy_gap || busy !== 1'b0) begin failures++; $display("FAIL single_busy gap=%b busy_at_done=%b exp=0/0", busy_gap, busy); end
`ifdef TJMONO2_RX_ALIGN_PASS_MAP_EN
    checks++; if (pass_map !== (64'h0001_FC00 << 32)) begin failures++; $display("FAIL single_map got=%h exp=%h", pass_map, 64'h0001_FC00 << 32); end
`else
    checks++; if (pass_map !== 64'd0) begin failures++; $display("FAIL single_map_tied got=%h exp=0", pass_map); end
`endif
  endtask

  task automatic test_tie();
    mask = (64'hF << 3) | (64'hF << 52);
    run_sweep();
    checks++; if (timed_out || done !== 1'b1) begin failures++; $display("FAIL tie_done to=%b done=%b exp=0/1", timed_out, done); end
    checks++; if (best_len !== 6'd4 || sedge !== 1'b0 || dly !== 5'd4) begin failures++; $display("FAIL tie_sel len=%0d edge=%b dly=%0d exp=4/0/4", best_len, sedge, dly); end
  endtask

  task automatic test_edge_boundary();
    mask = 64'h0000_0003_E000_0000;
    run_sweep();
    checks++; if (timed_out || done !== 1'b1) begin failures++; $display("FAIL edge_done to=%b done=%b exp=0/1", timed_out, done); end
    checks++; if (best_len !== 6'd3 || sedge !== 1'b0 || dly !== 5'd30) begin failures++; $display("FAIL edge_sel len=%0d edge=%b dly=%0d exp=3/0/30", best_len, sedge, dly); end
  endtask

  task automatic wait_load(input logic [5:0] target, output bit found);
    found = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if (conf_load && {sedge, dly} == target) begin found = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_abort();
    bit found;
    int extra;
    mask = '0;
    start = 1'b1; @(negedge clk); start = 1'b0;
    wait_load(6'd5, found);
    checks++; if (!found) begin failures++; $display("FAIL abort_reach5 got=timeout exp=load of setting 5"); end
    repeat (2) @(negedge clk);
    start = 1'b1; @(negedge clk); start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (conf_load) begin found = 1'b1; break; end
      @(negedge clk);
    end
    checks++; if (!found || {sedge, dly} !== 6'd6) begin failures++; $display("FAIL start_while_busy found=%b cfg=%0d exp=1/6", found, {sedge, dly}); end
    wait_load(6'd20, found);
    checks++; if (!found) begin failures++; $display("FAIL abort_reach20 got=timeout exp=load of setting 20"); end
    repeat (S + 2) @(negedge clk);
    checks++; if (busy !== 1'b1 || conf_load !== 1'b0) begin failures++; $display("FAIL abort_premeasure busy=%b load=%b exp=1/0", busy, conf_load); end
    abort = 1'b1; @(negedge clk); abort = 1'b0;
    checks++; if (busy !== 1'b0 || conf_load !== 1'b1 || rx_rst !== 1'b0) begin failures++; $display("FAIL abort_pulse busy=%b load=%b rst=%b exp=0/1/0", busy, conf_load, rx_rst); end
    checks++; if ({sedge, dly} !== 6'd30 || done !== 1'b0 || fail !== 1'b0) begin failures++; $display("FAIL abort_restore cfg=%0d done=%b fail=%b exp=30/0/0", {sedge, dly}, done, fail); end
    extra = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (conf_load || busy) extra++;
    end
    checks++; if (extra !== 0) begin failures++; $display("FAIL abort_idle activity=%0d exp=0", extra); end
    abort = 1'b1; @(negedge clk); abort = 1'b0;
    checks++; if (conf_load !== 1'b0 || {sedge, dly} !== 6'd30) begin failures++; $display("FAIL abort_in_idle load=%b cfg=%0d exp=0/30", conf_load, {sedge, dly}); end
    start = 1'b1; abort = 1'b1; @(negedge clk); start = 1'b0; abort = 1'b0;
    checks++; if (conf_load !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL abort_beats_start load=%b busy=%b exp=0/0", conf_load, busy); end
  endtask

  initial begin
    mask = '0; glitch_en = 1'b0;
    test_reset();
    test_fail();
    test_single_run();
    test_tie();
    test_edge_boundary();
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
